// File: rtl/pe_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pe_rd_arbiter
//  Description : Round-robin read-port arbiter that lets NUM_REQ PE controllers
//                share one single-port BRAM read port. One requester is granted
//                per cycle. A PE holding lock keeps the port for up to MAX_BURST
//                consecutive beats. Read data is broadcast to every PE, and a
//                one-hot rvalid marks the PE that owns it, RD_LAT cycles after
//                the grant.
//  Ports       : aclk/areset   - clock, synchronous active-high reset
//                req/lock      - per-PE request and burst-lock hint
//                req_addr      - flattened per-PE read addresses
//                gnt           - one-hot grant (combinational)
//                mem_en/addr   - BRAM read enable and address
//                mem_rdata     - BRAM read data (RD_LAT after mem_en)
//                rdata/rvalid  - broadcast data and one-hot return valid
//                busy          - a grant or a return is in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int L_RAM_SIZE = 6,
    parameter int ADDR_W     = 2*L_RAM_SIZE+1,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST+1);
    localparam logic [CNT_W-1:0] C_MAX_BURST = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] C_LAST_RST  = IDX_W'(NUM_REQ-1);

    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_owner;
    logic               r_owner_vld;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [NUM_REQ-1:0] r_rv_pipe [RD_LAT];

    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_idx;
    logic               w_found;
    logic               w_hold;
    logic               w_grant;
    logic               w_inflight;

    // Grant selection: keep the locked owner while its burst budget lasts,
    // otherwise scan round-robin starting just after the last winner.
    always_comb begin
        w_sel   = r_last;
        w_idx   = r_last;
        w_found = 1'b0;
        w_hold  = r_owner_vld && req[r_owner] && lock[r_owner] &&
                  (r_burst_cnt < C_MAX_BURST);
        if (w_hold) begin
            w_sel   = r_owner;
            w_found = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_idx = IDX_W'((int'(r_last) + k) % NUM_REQ);
                if (!w_found && req[w_idx]) begin
                    w_found = 1'b1;
                    w_sel   = w_idx;
                end
            end
        end
        w_grant = w_found && !areset;
    end

    assign gnt      = w_grant ? (NUM_REQ'(1) << w_sel) : '0;
    assign mem_en   = w_grant;
    assign mem_addr = w_grant ? req_addr[int'(w_sel)*ADDR_W +: ADDR_W] : '0;
    assign rdata    = mem_rdata;
    assign rvalid   = r_rv_pipe[RD_LAT-1];

    always_comb begin
        w_inflight = 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
            w_inflight = w_inflight | (|r_rv_pipe[k]);
        end
    end

    assign busy = !areset && (w_grant || w_inflight);

    // Round-robin pointer and burst bookkeeping. A grant to the current owner
    // extends its burst; once the budget is spent the count restarts at 1, so
    // a sole locked requester keeps the port with no idle cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_last      <= C_LAST_RST;
            r_owner     <= '0;
            r_owner_vld <= 1'b0;
            r_burst_cnt <= '0;
        end else if (w_grant) begin
            r_last      <= w_sel;
            r_owner     <= w_sel;
            r_owner_vld <= lock[w_sel];
            if (r_owner_vld && (r_owner == w_sel) && (r_burst_cnt < C_MAX_BURST)) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end else begin
                r_burst_cnt <= CNT_W'(1);
            end
        end else begin
            r_owner_vld <= 1'b0;
            r_burst_cnt <= '0;
        end
    end

    // Return-valid delay line matching the memory read latency; reset drops
    // any returns still in flight.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_rv_pipe[k] <= '0;
            end
        end else begin
            r_rv_pipe[0] <= gnt;
            for (int k = 1; k < RD_LAT; k++) begin
                r_rv_pipe[k] <= r_rv_pipe[k-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_rd_arbiter
//  Description : Self-checking bench for pe_rd_arbiter. Two instances share the
//                same requests, one with RD_LAT=1 and one with RD_LAT=3, each
//                with its own BRAM model. A behavioural arbitration model is
//                checked against both every cycle. Directed literal checks pin
//                the model, and a randomized phase follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          areset = 1'b1;
    logic [N-1:0]  req    = '1;
    logic [N-1:0]  lock   = '0;
    logic [N*AW-1:0] req_addr = '0;

    logic [N-1:0]  gnt1, rvalid1, gnt3, rvalid3;
    logic          mem_en1, busy1, mem_en3, busy3;
    logic [AW-1:0] mem_addr1, mem_addr3;
    logic [DW-1:0] mem_rdata1, rdata1, mem_rdata3, rdata3;

    pe_rd_arbiter #(.NUM_REQ(N), .L_RAM_SIZE(6), .ADDR_W(AW), .DATA_W(DW),
                    .RD_LAT(1), .MAX_BURST(MB)) u_dut1 (
        .aclk(clk), .areset(areset), .req(req), .lock(lock), .req_addr(req_addr),
        .gnt(gnt1), .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
        .rdata(rdata1), .rvalid(rvalid1), .busy(busy1));

    pe_rd_arbiter #(.NUM_REQ(N), .L_RAM_SIZE(6), .ADDR_W(AW), .DATA_W(DW),
                    .RD_LAT(3), .MAX_BURST(MB)) u_dut3 (
        .aclk(clk), .areset(areset), .req(req), .lock(lock), .req_addr(req_addr),
        .gnt(gnt3), .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_rdata(mem_rdata3),
        .rdata(rdata3), .rvalid(rvalid3), .busy(busy3));

    // BRAM contents are a fixed hash of the address.
    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return ({19'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    logic [AW-1:0] ap1 = '0;
    logic [AW-1:0] ap3 [3];
    initial begin
        for (int i = 0; i < 3; i++) ap3[i] = '0;
    end
    always @(posedge clk) begin
        ap1    <= mem_addr1;
        ap3[0] <= mem_addr3;
        ap3[1] <= ap3[0];
        ap3[2] <= ap3[1];
    end
    assign mem_rdata1 = memf(ap1);
    assign mem_rdata3 = memf(ap3[2]);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_last = N-1;
    int            m_own  = -1;
    int            m_cnt  = 0;
    logic [N-1:0]  gq [3];          // grants of the last 3 cycles, [0] newest
    logic [AW-1:0] aq [3];          // matching addresses
    bit            started = 1'b0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            gq[i] = '0;
            aq[i] = '0;
        end
    end

    function automatic int model_grant();
        if (areset || req == '0) return -1;
        if (m_own >= 0 && req[m_own] && lock[m_own] && m_cnt < MB) return m_own;
        for (int k = 1; k <= N; k++) begin
            int i = (m_last + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    int            eg;
    logic [N-1:0]  eoh;
    logic [AW-1:0] ea;

    always @(negedge clk) begin
        if (started) begin
            eg  = model_grant();
            eoh = (eg >= 0) ? (4'b0001 << eg) : 4'b0000;
            ea  = (eg >= 0) ? req_addr[eg*AW +: AW] : '0;
            chk("gnt1", gnt1, eoh);
            chk("gnt3", gnt3, eoh);
            chk("mem_en1", mem_en1, eg >= 0);
            chk("mem_en3", mem_en3, eg >= 0);
            chk("mem_addr1", mem_addr1, ea);
            chk("mem_addr3", mem_addr3, ea);
            chk("rvalid1", rvalid1, gq[0]);
            chk("rvalid3", rvalid3, gq[2]);
            if (gq[0] != '0) chk("rdata1", rdata1, memf(aq[0]));
            if (gq[2] != '0) chk("rdata3", rdata3, memf(aq[2]));
            chk("busy1", busy1, !areset && (eg >= 0 || gq[0] != '0));
            chk("busy3", busy3, !areset && (eg >= 0 || (gq[0] | gq[1] | gq[2]) != '0));
            // advance the model across the coming rising edge
            if (areset) begin
                m_last = N-1;
                m_own  = -1;
                m_cnt  = 0;
                for (int i = 0; i < 3; i++) gq[i] = '0;
            end else if (eg >= 0) begin
                m_cnt  = (eg == m_own && m_cnt < MB) ? m_cnt + 1 : 1;
                m_last = eg;
                m_own  = lock[eg] ? eg : -1;
            end else begin
                m_own = -1;
                m_cnt = 0;
            end
            gq[2] = gq[1]; gq[1] = gq[0]; gq[0] = eoh;
            aq[2] = aq[1]; aq[1] = aq[0]; aq[0] = ea;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic rs, input logic [N-1:0] r, input logic [N-1:0] l);
        @(posedge clk);
        #1;
        areset = rs;
        req    = r;
        lock   = l;
    endtask

    task automatic rand_addr();
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
    endtask

    logic [N-1:0] rr_exp [8];
    logic [N-1:0] bu_exp [10];

    initial begin
        rr_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
        bu_exp = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4};
        rand_addr();
        @(posedge clk);
        #1;
        started = 1'b1;
        // reset held for three cycles with everyone requesting
        @(negedge clk);
        chk("lit_rst_gnt", gnt1, 4'h0);
        chk("lit_rst_busy", busy1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            cyc(1'b1, 4'b1111, 4'b0000);
            @(negedge clk);
            chk("lit_rst_gnt", gnt1, 4'h0);
            chk("lit_rst_rvalid", rvalid1, 4'h0);
            chk("lit_rst_busy3", busy3, 1'b0);
        end
        // round robin, no lock
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 4'b1111, 4'b0000);
            rand_addr();
            @(negedge clk);
            chk("lit_rr_gnt", gnt1, rr_exp[c]);
            if (c > 0) chk("lit_rr_rvalid", rvalid1, rr_exp[c-1]);
        end
        cyc(1'b0, 4'b0000, 4'b0000);
        // locked burst from PE1 against PE2
        for (int c = 0; c < 10; c++) begin
            cyc(1'b0, 4'b0110, 4'b0010);
            rand_addr();
            @(negedge clk);
            chk("lit_burst_gnt", gnt1, bu_exp[c]);
        end
        cyc(1'b0, 4'b0000, 4'b0000);
        // sole locked requester never loses the port
        for (int c = 0; c < 10; c++) begin
            cyc(1'b0, 4'b1000, 4'b1000);
            @(negedge clk);
            chk("lit_sole_gnt", gnt1, 4'h8);
        end
        cyc(1'b0, 4'b0000, 4'b0000);
        // latency/alignment on the RD_LAT=3 instance
        cyc(1'b0, 4'b0001, 4'b0000);
        req_addr[0*AW +: AW] = 13'h0005;
        cyc(1'b0, 4'b0100, 4'b0000);
        req_addr[2*AW +: AW] = 13'h1040;
        cyc(1'b0, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("lit_lat_rvalid0", rvalid3, 4'b0001);
        chk("lit_lat_rdata0", rdata3, memf(13'h0005));
        cyc(1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("lit_lat_rvalid2", rvalid3, 4'b0100);
        chk("lit_lat_rdata2", rdata3, memf(13'h1040));
        // reset one cycle after a locked grant drops the return
        cyc(1'b0, 4'b0010, 4'b0010);
        @(negedge clk);
        chk("lit_mid_gnt", gnt1, 4'b0010);
        cyc(1'b1, 4'b0010, 4'b0010);
        @(negedge clk);
        chk("lit_mid_rst_gnt", gnt1, 4'b0000);
        cyc(1'b0, 4'b0011, 4'b0000);
        @(negedge clk);
        chk("lit_mid_ptr", gnt1, 4'b0001);
        chk("lit_mid_rv3a", rvalid3, 4'b0000);
        cyc(1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("lit_mid_rv3b", rvalid3, 4'b0000);
        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            cyc(($urandom % 64) == 0, N'($urandom), N'($urandom | $urandom));
            rand_addr();
        end
        for (int c = 0; c < 5; c++) cyc(1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
